// File: rtl/unidade_controle_mc_pkg.sv
// Shared state codes, opcode/funct values and datapath select encodings
// for the multicycle control unit.
package controle_pkg;

  typedef enum logic [5:0] {
    S_FETCH     = 6'd0,
    S_WAIT      = 6'd1,
    S_IR_WRITE  = 6'd2,
    S_DECODE    = 6'd3,
    S_R_EXEC    = 6'd4,
    S_R_WB      = 6'd5,
    S_ADDI_EXEC = 6'd6,
    S_ADDI_WB   = 6'd7,
    S_ADDR      = 6'd8,
    S_LOAD_RD   = 6'd9,
    S_LOAD_WB   = 6'd10,
    S_STORE     = 6'd11,
    S_BEQ       = 6'd12,
    S_BNE       = 6'd13,
    S_LUI       = 6'd14,
    S_JUMP      = 6'd15,
    S_NOP       = 6'd16,
    S_EXC_OP    = 6'd17,
    S_EXC_OVF   = 6'd18,
    S_BREAK     = 6'd19
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_BREAK = 6'h0d;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_EXC    = 2'b11;

  localparam logic [1:0] ALUB_B      = 2'b00;
  localparam logic [1:0] ALUB_4      = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_LUI    = 2'b10;

  localparam logic CAUSA_OPCODE = 1'b0;
  localparam logic CAUSA_OVF    = 1'b1;

  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_t nxt;
    nxt = S_EXC_OP;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_BREAK)    nxt = S_BREAK;
        else if (fn == FN_NOP) nxt = S_NOP;
        else                   nxt = S_R_EXEC;
      end
      OP_J:          nxt = S_JUMP;
      OP_BEQ:        nxt = S_BEQ;
      OP_BNE:        nxt = S_BNE;
      OP_ADDI:       nxt = S_ADDI_EXEC;
      OP_LUI:        nxt = S_LUI;
      OP_LW, OP_SW:  nxt = S_ADDR;
      default:       nxt = S_EXC_OP;
    endcase
    return nxt;
  endfunction

  // States whose exit to FETCH marks a successfully completed instruction.
  function automatic logic retires(input state_t s);
    logic r;
    case (s)
      S_R_WB, S_ADDI_WB, S_LOAD_WB, S_STORE, S_BEQ,
      S_BNE, S_LUI, S_JUMP, S_NOP: r = 1'b1;
      default:                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/unidade_controle_mc_wait.sv
// Memory wait counter: runs while start is held, cleared otherwise;
// done once MEM_LATENCY cycles have elapsed since start first rose.
module mem_wait_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic done
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  assign done = (cnt_q == 4'(MEM_LATENCY));

  always_comb begin
    cnt_d = cnt_q;
    if (!start)     cnt_d = '0;
    else if (!done) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/unidade_controle_mc.sv
// Multicycle MIPS-subset control FSM with configurable memory latency,
// precise exceptions (EPC/cause) and a retired-instruction counter.
module unidade_controle_mc
  import controle_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       OPcode,
  input  logic [5:0]       funct,
  input  logic             Overflow,
  output logic             EscreveMem,
  output logic             EscrevePC,
  output logic             EscrevePCCondEQ,
  output logic             EscrevePCCondNE,
  output logic [1:0]       OrigPC,
  output logic             RegDst,
  output logic             EscreveReg,
  output logic [1:0]       MemparaReg,
  output logic             IouD,
  output logic             EscreveIR,
  output logic             EscreveMDR,
  output logic             EscreveAluOut,
  output logic             OrigAALU,
  output logic [1:0]       OrigBALU,
  output logic [1:0]       OpALU,
  output logic             EscreveEPC,
  output logic             Causa,
  output logic             Halted,
  output logic [CNT_W-1:0] RetiredCount,
  output logic [5:0]       State
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             wait_start;
  logic             wait_done;

  // FETCH is the request cycle, so it counts as the first elapsed cycle of WAIT.
  mem_wait_counter #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
    .clock (clock),
    .reset (reset),
    .start (wait_start),
    .done  (wait_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_start = 1'b0;
    retired_d  = retires(state_q) ? retired_q + CNT_W'(1) : retired_q;
    case (state_q)
      S_FETCH: begin
        wait_start = 1'b1;
        state_d    = wait_done ? S_IR_WRITE : S_WAIT;
      end
      S_WAIT: begin
        wait_start = 1'b1;
        if (wait_done) state_d = S_IR_WRITE;
      end
      S_IR_WRITE:  state_d = S_DECODE;
      S_DECODE:    state_d = decode_next(OPcode, funct);
      S_R_EXEC:    state_d = (Overflow && (funct == FN_ADD || funct == FN_SUB)) ? S_EXC_OVF : S_R_WB;
      S_ADDI_EXEC: state_d = Overflow ? S_EXC_OVF : S_ADDI_WB;
      S_ADDR:      state_d = (OPcode == OP_LW) ? S_LOAD_RD : S_STORE;
      S_LOAD_RD: begin
        wait_start = 1'b1;
        if (wait_done) state_d = S_LOAD_WB;
      end
      S_BREAK:     state_d = S_BREAK;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    EscreveMem      = 1'b0;
    EscrevePC       = 1'b0;
    EscrevePCCondEQ = 1'b0;
    EscrevePCCondNE = 1'b0;
    OrigPC          = PC_SRC_ALU;
    RegDst          = 1'b0;
    EscreveReg      = 1'b0;
    MemparaReg      = M2R_ALUOUT;
    IouD            = 1'b0;
    EscreveIR       = 1'b0;
    EscreveMDR      = 1'b0;
    EscreveAluOut   = 1'b0;
    OrigAALU        = 1'b0;
    OrigBALU        = ALUB_B;
    OpALU           = ALUOP_ADD;
    EscreveEPC      = 1'b0;
    Causa           = CAUSA_OPCODE;
    Halted          = 1'b0;
    case (state_q)
      S_IR_WRITE: begin
        EscreveIR = 1'b1;
        EscrevePC = 1'b1;
        OrigBALU  = ALUB_4;
        OpALU     = ALUOP_ADD;
        OrigPC    = PC_SRC_ALU;
      end
      S_DECODE: begin
        OrigBALU      = ALUB_IMM_SH;
        EscreveAluOut = 1'b1;
      end
      S_R_EXEC: begin
        OrigAALU      = 1'b1;
        OrigBALU      = ALUB_B;
        OpALU         = ALUOP_FUNCT;
        EscreveAluOut = 1'b1;
      end
      S_R_WB: begin
        RegDst     = 1'b1;
        EscreveReg = 1'b1;
        MemparaReg = M2R_ALUOUT;
      end
      S_ADDI_EXEC, S_ADDR: begin
        OrigAALU      = 1'b1;
        OrigBALU      = ALUB_IMM;
        EscreveAluOut = 1'b1;
      end
      S_ADDI_WB: EscreveReg = 1'b1;
      // MDR captures only once the data has arrived, on the final wait cycle.
      S_LOAD_RD: begin
        IouD       = 1'b1;
        EscreveMDR = wait_done;
      end
      S_LOAD_WB: begin
        MemparaReg = M2R_MDR;
        EscreveReg = 1'b1;
      end
      S_STORE: begin
        IouD       = 1'b1;
        EscreveMem = 1'b1;
      end
      S_BEQ, S_BNE: begin
        OrigAALU        = 1'b1;
        OrigBALU        = ALUB_B;
        OpALU           = ALUOP_SUB;
        OrigPC          = PC_SRC_ALUOUT;
        EscrevePCCondEQ = (state_q == S_BEQ);
        EscrevePCCondNE = (state_q == S_BNE);
      end
      S_LUI: begin
        MemparaReg = M2R_LUI;
        EscreveReg = 1'b1;
      end
      S_JUMP: begin
        OrigPC    = PC_SRC_JUMP;
        EscrevePC = 1'b1;
      end
      // PC already advanced by 4, so PC-4 recovers the faulting address.
      S_EXC_OP, S_EXC_OVF: begin
        EscreveEPC = 1'b1;
        OrigBALU   = ALUB_4;
        OpALU      = ALUOP_SUB;
        Causa      = (state_q == S_EXC_OVF) ? CAUSA_OVF : CAUSA_OPCODE;
        OrigPC     = PC_SRC_EXC;
        EscrevePC  = 1'b1;
      end
      S_BREAK: Halted = 1'b1;
      default: ;
    endcase
  end

  assign RetiredCount = retired_q;
  assign State        = state_q;

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Bench for unidade_controle_mc: three instances (latency 1, 3, 0) checked
// cycle by cycle against per-instruction expected control traces.
module tb_unidade_controle_mc;

  typedef struct packed {
    logic       mem_w;
    logic       pc_w;
    logic       cond_eq;
    logic       cond_ne;
    logic [1:0] orig_pc;
    logic       reg_dst;
    logic       reg_w;
    logic [1:0] mem2reg;
    logic       iord;
    logic       ir_w;
    logic       mdr_w;
    logic       aluout_w;
    logic       orig_a;
    logic [1:0] orig_b;
    logic [1:0] op_alu;
    logic       epc_w;
    logic       causa;
    logic       halted;
  } ctl_t;

  typedef struct {
    ctl_t c;
    int   st;   // >=0 exact code, -1 don't care, -2 must stay constant
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  op_s   [3];
  logic [5:0]  fn_s   [3];
  logic        ovf_s  [3];
  logic        rst_s  [3];
  ctl_t        obs    [3];
  logic [5:0]  st_obs [3];
  logic [31:0] cnt_obs[3];

  int     n_assert = 0;
  int     n_fail   = 0;
  longint model_cnt[3];
  exp_t   q[$];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 0);
      localparam int CW  = (gi == 2) ? 4 : 32;
      logic em, pcw, ceq, cne, rdst, rw, iord, irw, mdrw, aow, oa, epcw, causa, halt;
      logic [1:0] opc, m2r, ob, opalu;
      logic [CW-1:0] rc;
      logic [5:0] st;
      unidade_controle_mc #(.MEM_LATENCY(LAT), .CNT_W(CW)) u_dut (
        .clock(clk), .reset(rst_s[gi]), .OPcode(op_s[gi]), .funct(fn_s[gi]),
        .Overflow(ovf_s[gi]), .EscreveMem(em), .EscrevePC(pcw),
        .EscrevePCCondEQ(ceq), .EscrevePCCondNE(cne), .OrigPC(opc),
        .RegDst(rdst), .EscreveReg(rw), .MemparaReg(m2r), .IouD(iord),
        .EscreveIR(irw), .EscreveMDR(mdrw), .EscreveAluOut(aow),
        .OrigAALU(oa), .OrigBALU(ob), .OpALU(opalu), .EscreveEPC(epcw),
        .Causa(causa), .Halted(halt), .RetiredCount(rc), .State(st)
      );
      assign obs[gi]     = {em, pcw, ceq, cne, opc, rdst, rw, m2r, iord, irw,
                            mdrw, aow, oa, ob, opalu, epcw, causa, halt};
      assign st_obs[gi]  = st;
      assign cnt_obs[gi] = 32'(rc);
    end
  endgenerate

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  function automatic logic [31:0] cmask(input int k);
    return (k == 2) ? 32'h0000_000f : 32'hffff_ffff;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0f, 6'h23, 6'h2b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic push(input ctl_t c, input int st);
    exp_t x;
    x.c  = c;
    x.st = st;
    q.push_back(x);
  endtask

  function automatic ctl_t exc_vec(input logic cause);
    ctl_t e;
    e = '0;
    e.epc_w   = 1'b1;
    e.orig_b  = 2'b01;
    e.op_alu  = 2'b01;
    e.causa   = cause;
    e.orig_pc = 2'b11;
    e.pc_w    = 1'b1;
    return e;
  endfunction

  // Expected per-cycle control trace of one instruction, from FETCH to its last state.
  task automatic build(input int lat, input logic [5:0] op, input logic [5:0] fn,
                       input logic ovf, output bit retire);
    ctl_t z, e;
    z = '0;
    retire = 1'b1;
    q.delete();
    push(z, 0);
    for (int i = 0; i < lat; i++) push(z, 1);
    e = z; e.ir_w = 1'b1; e.pc_w = 1'b1; e.orig_b = 2'b01; push(e, 2);
    e = z; e.orig_b = 2'b11; e.aluout_w = 1'b1; push(e, 3);
    e = z;
    if (op == 6'h00 && fn == 6'h0d) begin
      e.halted = 1'b1;
      for (int i = 0; i < 20; i++) push(e, -2);
      retire = 1'b0;
    end else if (op == 6'h00 && fn == 6'h00) begin
      push(z, -1);
    end else if (op == 6'h00) begin
      e.orig_a = 1'b1; e.op_alu = 2'b10; e.aluout_w = 1'b1; push(e, -1);
      if (ovf && (fn == 6'h20 || fn == 6'h22)) begin
        push(exc_vec(1'b1), -1);
        retire = 1'b0;
      end else begin
        e = z; e.reg_dst = 1'b1; e.reg_w = 1'b1; push(e, -1);
      end
    end else if (op == 6'h08) begin
      e.orig_a = 1'b1; e.orig_b = 2'b10; e.aluout_w = 1'b1; push(e, -1);
      if (ovf) begin
        push(exc_vec(1'b1), -1);
        retire = 1'b0;
      end else begin
        e = z; e.reg_w = 1'b1; push(e, -1);
      end
    end else if (op == 6'h23 || op == 6'h2b) begin
      e.orig_a = 1'b1; e.orig_b = 2'b10; e.aluout_w = 1'b1; push(e, -1);
      e = z; e.iord = 1'b1;
      if (op == 6'h23) begin
        for (int i = 0; i <= lat; i++) begin
          e.mdr_w = (i == lat);
          push(e, -1);
        end
        e = z; e.mem2reg = 2'b01; e.reg_w = 1'b1; push(e, -1);
      end else begin
        e.mem_w = 1'b1; push(e, -1);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      e.orig_a = 1'b1; e.op_alu = 2'b01; e.orig_pc = 2'b01;
      e.cond_eq = (op == 6'h04); e.cond_ne = (op == 6'h05);
      push(e, -1);
    end else if (op == 6'h0f) begin
      e.mem2reg = 2'b10; e.reg_w = 1'b1; push(e, -1);
    end else if (op == 6'h02) begin
      e.orig_pc = 2'b10; e.pc_w = 1'b1; push(e, -1);
    end else begin
      push(exc_vec(1'b0), -1);
      retire = 1'b0;
    end
  endtask

  task automatic check_trace(input int k, input int limit);
    int ref_st;
    ref_st = -1;
    for (int i = 0; i < limit && i < q.size(); i++) begin
      chk($sformatf("u%0d ctl cyc%0d", k, i), 32'(obs[k]), 32'(q[i].c));
      if (q[i].st >= 0)
        chk($sformatf("u%0d state cyc%0d", k, i), 32'(st_obs[k]), 32'(q[i].st));
      else if (q[i].st == -2) begin
        if (ref_st < 0) ref_st = int'(st_obs[k]);
        else chk($sformatf("u%0d halt state cyc%0d", k, i), 32'(st_obs[k]), 32'(ref_st));
      end
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn, input logic ovf);
    bit ret;
    op_s[k]  = op;
    fn_s[k]  = fn;
    ovf_s[k] = ovf;
    build(lat_of(k), op, fn, ovf, ret);
    check_trace(k, 1000);
    if (ret) model_cnt[k]++;
    chk($sformatf("u%0d retired", k), cnt_obs[k], 32'(model_cnt[k]) & cmask(k));
    $display("u%0d op=%h fn=%h ovf=%b cycles=%0d retired=%0d", k, op, fn, ovf, q.size(), cnt_obs[k]);
  endtask

  task automatic do_reset(input int k, input int n);
    rst_s[k] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("u%0d rst ctl", k), 32'(obs[k]), 32'd0);
      chk($sformatf("u%0d rst state", k), 32'(st_obs[k]), 32'd0);
      chk($sformatf("u%0d rst retired", k), cnt_obs[k], 32'd0);
    end
    rst_s[k] = 1'b0;
    model_cnt[k] = 0;
  endtask

  task automatic run_random(input int k, input int n);
    logic [5:0] op, fn;
    logic ovf;
    for (int i = 0; i < n; i++) begin
      op  = 6'h00;
      fn  = 6'($urandom_range(0, 63));
      ovf = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 11))
        0:  if (fn == 6'h0d || fn == 6'h00) fn = 6'h24;
        1:  fn = ($urandom_range(0, 1) == 1) ? 6'h20 : 6'h22;
        2:  fn = 6'h00;
        3:  op = 6'h08;
        4:  op = 6'h23;
        5:  op = 6'h2b;
        6:  op = 6'h04;
        7:  op = 6'h05;
        8:  op = 6'h0f;
        9:  op = 6'h02;
        10: begin
          op = 6'($urandom_range(0, 63));
          while (legal(op)) op = 6'($urandom_range(0, 63));
        end
        default: fn = 6'h2a;
      endcase
      run_instr(k, op, fn, ovf);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      op_s[k] = '0; fn_s[k] = '0; ovf_s[k] = 1'b0; rst_s[k] = 1'b1; model_cnt[k] = 0;
    end
    repeat (3) @(negedge clk);

    // Instance 0: latency 1
    do_reset(0, 1);
    run_instr(0, 6'h00, 6'h20, 1'b0);
    run_instr(0, 6'h08, 6'h11, 1'b1);
    run_instr(0, 6'h3f, 6'h00, 1'b0);
    run_instr(0, 6'h23, 6'h00, 1'b0);
    // Abort a load in its first LOAD_RD cycle
    op_s[0] = 6'h23; fn_s[0] = 6'h00; ovf_s[0] = 1'b0;
    begin
      bit r;
      build(1, 6'h23, 6'h00, 1'b0, r);
    end
    check_trace(0, 5);
    chk("u0 load_rd first", 32'(obs[0]), 32'(q[5].c));
    do_reset(0, 3);
    run_random(0, 40);
    run_instr(0, 6'h00, 6'h0d, 1'b0);
    do_reset(0, 2);
    run_instr(0, 6'h0f, 6'h00, 1'b0);
    rst_s[0] = 1'b1;

    // Instance 1: latency 3
    do_reset(1, 1);
    run_instr(1, 6'h00, 6'h20, 1'b0);
    run_instr(1, 6'h00, 6'h22, 1'b1);
    run_instr(1, 6'h00, 6'h25, 1'b1);
    run_random(1, 40);
    rst_s[1] = 1'b1;

    // Instance 2: latency 0, 4-bit retired counter
    do_reset(2, 1);
    run_instr(2, 6'h23, 6'h00, 1'b0);
    run_instr(2, 6'h2b, 6'h00, 1'b0);
    run_random(2, 40);
    rst_s[2] = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
